// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM encoding and command record shared by the ALU sequencer
package alu_seq_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;
  typedef struct packed {
    logic        load;
    logic [2:0]  op;
    logic [15:0] data;
  } cmd_t;
  localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with explicit occupancy count and a flush that empties it
module cmd_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: drives a combinational ALU from queued commands through an accumulator
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [15:0]      cmd_data,
  output logic [15:0]      alu_x,
  output logic [15:0]      alu_y,
  output logic [2:0]       alu_op,
  input  logic [16:0]      alu_out,
  input  logic             alu_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [16:0]      res_data,
  output logic             res_err,
  output logic             busy,
  output logic             err_state,
  input  logic             err_clear,
  output logic [CNT_W-1:0] ops_done
);
  logic [1:0] state;
  cmd_t cur, head;
  logic [16:0] acc, nxt;
  logic [15:0] x_q;
  logic full, empty, push, pop, flush, hs;
  assign hs = state == RESP && res_ready;
  assign push = cmd_valid && cmd_ready;
  assign pop = !empty && (state == IDLE || (hs && !res_err));
  assign flush = hs && res_err;
  assign cmd_ready = !full && state != ERROR;
  assign res_valid = state == RESP;
  assign err_state = state == ERROR;
  assign busy = state != IDLE || !empty;
  // x is live only in EXEC; elsewhere it holds the value the ALU last saw
  assign alu_x = state == EXEC ? acc[15:0] : x_q;
  assign alu_y = cur.data;
  assign alu_op = cur.op;
  assign nxt = cur.load ? {1'b0, cur.data} : alu_err ? 17'h0 : alu_out;
  cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din({cmd_load, cmd_op, cmd_data}),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cur <= '0;
      acc <= '0;
      x_q <= '0;
      res_data <= '0;
      res_err <= 1'b0;
      ops_done <= '0;
    end else begin
      if (pop) cur <= head;
      case (state)
        IDLE: if (!empty) state <= EXEC;
        EXEC: begin
          state <= RESP;
          x_q <= acc[15:0];
          acc <= nxt;
          res_data <= nxt;
          res_err <= !cur.load && alu_err;
        end
        RESP: if (res_ready) begin
          state <= res_err ? ERROR : !empty ? EXEC : IDLE;
          if (!res_err) ops_done <= ops_done + 1'b1;
        end
        default: begin
          acc <= '0;
          if (err_clear) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed vector table plus hand sequences for error, backpressure and reset
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;
  typedef struct packed {
    logic        load;
    logic [2:0]  op;
    logic [15:0] data;
    logic [16:0] exp;
    logic        exp_err;
  } vec_t;
  logic clk = 0, reset = 1, cmd_valid = 0, cmd_load = 0, res_ready = 0, err_clear = 0;
  logic [2:0] cmd_op = 0;
  logic [15:0] cmd_data = 0;
  logic cmd_ready, res_valid, res_err, busy, err_state, alu_err;
  logic [15:0] alu_x, alu_y, ops_done, ex, ey;
  logic [2:0] alu_op, eop;
  logic [16:0] alu_out, res_data, acc_m;
  int tests = 0, fails = 0, exp_ops = 0;
  always #5 clk = ~clk;
  alu_cmd_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_out(alu_out), .alu_err(alu_err),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .err_state(err_state), .err_clear(err_clear), .ops_done(ops_done)
  );
  // reference ALU: add flags carry-out, sub flags borrow, shifts move by one bit
  always_comb begin
    alu_err = 1'b0;
    alu_out = 17'h0;
    case (alu_op)
      OP_ADD: begin alu_out = {1'b0, alu_x} + {1'b0, alu_y}; alu_err = alu_out[16]; end
      OP_SUB: begin alu_out = {1'b0, alu_x} - {1'b0, alu_y}; alu_err = alu_x < alu_y; end
      OP_SHL: alu_out = {alu_x, 1'b0};
      OP_SHR: alu_out = {2'b0, alu_x[15:1]};
      OP_AND: alu_out = {1'b0, alu_x & alu_y};
      OP_OR:  alu_out = {1'b0, alu_x | alu_y};
      OP_XOR: alu_out = {1'b0, alu_x ^ alu_y};
      default: alu_out = {1'b0, ~alu_x};
    endcase
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", nm);
  endtask
  task automatic push(input logic l, input logic [2:0] o, input logic [15:0] d);
    int n = 0;
    cmd_valid = 1; cmd_load = l; cmd_op = o; cmd_data = d;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) fail("push_timeout");
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic wait_res(output int n);
    n = 1;
    while (!res_valid && n < 20) begin
      ex = alu_x; ey = alu_y; eop = alu_op;
      @(negedge clk);
      n++;
    end
    if (!res_valid) fail("res_timeout");
  endtask
  task automatic handshake();
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask
  task automatic run_vec(input string t, input vec_t v);
    int n;
    push(v.load, v.op, v.data);
    wait_res(n);
    chk({t, "_latency"}, 32'(n), 3);
    chk({t, "_res_data"}, 32'(res_data), 32'(v.exp));
    chk({t, "_res_err"}, 32'(res_err), 32'(v.exp_err));
    chk({t, "_alu_y"}, 32'(ey), 32'(v.data));
    chk({t, "_alu_x"}, 32'(ex), 32'(acc_m[15:0]));
    if (!v.load) chk({t, "_alu_op"}, 32'(eop), 32'(v.op));
    handshake();
    acc_m = v.exp_err ? 17'h0 : v.exp;
    if (!v.exp_err) exp_ops++;
    chk({t, "_ops_done"}, 32'(ops_done), 32'(exp_ops));
  endtask
  task automatic chk_reset(input string t);
    chk({t, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({t, "_res_valid"}, 32'(res_valid), 0);
    chk({t, "_res_data"}, 32'(res_data), 0);
    chk({t, "_res_err"}, 32'(res_err), 0);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_err_state"}, 32'(err_state), 0);
    chk({t, "_ops_done"}, 32'(ops_done), 0);
    chk({t, "_alu_xyop"}, {13'h0, alu_op, alu_x | alu_y}, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t tbl[13];
    vec_t v;
    logic rdy[6];
    int n, got, last;
    tbl[0]  = '{1'b1, OP_ADD, 16'h0005, 17'h00005, 1'b0};
    tbl[1]  = '{1'b0, OP_ADD, 16'h0003, 17'h00008, 1'b0};
    tbl[2]  = '{1'b1, OP_ADD, 16'h0008, 17'h00008, 1'b0};
    tbl[3]  = '{1'b0, OP_SUB, 16'h0003, 17'h00005, 1'b0};
    tbl[4]  = '{1'b0, OP_SHL, 16'h0000, 17'h0000A, 1'b0};
    tbl[5]  = '{1'b0, OP_SHR, 16'h0000, 17'h00005, 1'b0};
    tbl[6]  = '{1'b1, OP_ADD, 16'h00F0, 17'h000F0, 1'b0};
    tbl[7]  = '{1'b0, OP_AND, 16'h0FF0, 17'h000F0, 1'b0};
    tbl[8]  = '{1'b0, OP_OR,  16'h000F, 17'h000FF, 1'b0};
    tbl[9]  = '{1'b0, OP_XOR, 16'h00FF, 17'h00000, 1'b0};
    tbl[10] = '{1'b0, OP_NOT, 16'h0000, 17'h0FFFF, 1'b0};
    tbl[11] = '{1'b0, OP_SHL, 16'h0000, 17'h1FFFE, 1'b0};
    tbl[12] = '{1'b0, OP_SHR, 16'h0000, 17'h07FFF, 1'b0};
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset = 0;
    acc_m = 0;
    @(negedge clk);
    for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), tbl[i]);
    v = '{1'b1, OP_ADD, 16'hFFFF, 17'h0FFFF, 1'b0};
    run_vec("err_load", v);
    push(1'b0, OP_ADD, 16'h0001);
    wait_res(n);
    chk("err_res_err", 32'(res_err), 1);
    chk("err_res_data", 32'(res_data), 0);
    push(1'b0, OP_ADD, 16'h0002);
    push(1'b1, OP_ADD, 16'h1234);
    chk("err_busy_queued", 32'(busy), 1);
    handshake();
    chk("err_state", 32'(err_state), 1);
    chk("err_cmd_ready", 32'(cmd_ready), 0);
    chk("err_res_valid", 32'(res_valid), 0);
    repeat (3) @(negedge clk);
    chk("err_ops_done", 32'(ops_done), 32'(exp_ops));
    err_clear = 1;
    @(negedge clk);
    err_clear = 0;
    chk("clr_err_state", 32'(err_state), 0);
    chk("clr_cmd_ready", 32'(cmd_ready), 1);
    chk("clr_busy_flushed", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("clr_no_stale_res", 32'(res_valid), 0);
    acc_m = 0;
    v = '{1'b0, OP_ADD, 16'h0007, 17'h00007, 1'b0};
    run_vec("clr_acc0", v);
    res_ready = 0;
    for (int k = 0; k < 6; k++) begin
      cmd_valid = 1; cmd_load = k == 0; cmd_op = OP_ADD; cmd_data = 16'h0001;
      rdy[k] = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 0;
    for (int k = 0; k < 6; k++) chk($sformatf("bp_ready%0d", k), 32'(rdy[k]), k < 5 ? 1 : 0);
    res_ready = 1;
    got = 0;
    last = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (res_valid) begin
        chk($sformatf("bp_res%0d", got), 32'(res_data), 32'(got + 1));
        if (got > 0) chk($sformatf("bp_gap%0d", got), 32'(c - last), 2);
        last = c;
        got++;
      end
      @(negedge clk);
    end
    res_ready = 0;
    if (got != 5) fail("bp_results");
    exp_ops += 5;
    chk("bp_ops_done", 32'(ops_done), 32'(exp_ops));
    chk("bp_idle", 32'(busy), 0);
    push(1'b0, OP_ADD, 16'h0011);
    push(1'b0, OP_SUB, 16'h0001);
    chk("rst_pre_exec_y", 32'(alu_y), 32'h11);
    chk("rst_pre_busy", 32'(busy), 1);
    reset = 1;
    @(negedge clk);
    chk_reset("midrst");
    reset = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_res", 32'(res_valid), 0);
    chk("midrst_queue_empty", 32'(busy), 0);
    acc_m = 0;
    exp_ops = 0;
    v = '{1'b0, OP_ADD, 16'h0002, 17'h00002, 1'b0};
    run_vec("midrst_acc0", v);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequences the 16-bit ALU datapath (3-bit op, 17-bit result, overflow/underflow error flag) from a stream of queued commands.
- Holds a 17-bit accumulator that feeds the ALU x operand. Each command's operand feeds y. Each ALU result is written back to the accumulator and returned on a result handshake.
- Sits between a command source (testbench or host FSM) and a combinational ALU instance. The error flag drives a sticky ERROR state that must be cleared explicitly.

Parameters:
- FIFO_DEPTH, 4, command queue entries (power of 2, ≥2)
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  queue can accept command
- cmd_load  in  1  1 = load accumulator with cmd_data, no ALU operation
- cmd_op  in  3  ALU op code: 000 add, 001 sub, 010 shl, 011 shr, 100 and, 101 or, 110 xor, 111 not
- cmd_data  in  16  y operand or load value
- alu_x  out  16  to ALU x (accumulator bits 15:0)
- alu_y  out  16  to ALU y
- alu_op  out  3  to ALU op
- alu_out  in  17  ALU result
- alu_err  in  1  ALU error flag
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  17  result value
- res_err  out  1  result was an ALU error
- busy  out  1  state != IDLE or queue non-empty
- err_state  out  1  sequencer in ERROR state
- err_clear  in  1  leave ERROR state (single-cycle pulse)
- ops_done  out  CNT_W  count of error-free results delivered

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-high. Port names are clk and reset.
  - Reset is sampled every cycle and overrides everything, including mid-operation. Any in-flight command or pending result is discarded.
- Reset values: queue empty, state IDLE, accumulator 0, cmd_ready 1, res_valid 0, res_data 0, res_err 0, busy 0, err_state 0, ops_done 0, alu_x/alu_y/alu_op 0.
- Queue:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full && state != ERROR.
  - Simultaneous push and pop while full is not allowed; cmd_ready is already 0 when full.
  - Pointers wrap modulo FIFO_DEPTH. The queue keeps an explicit count to distinguish full from empty.
- State IDLE:
  - If the queue is non-empty: pop the head into the current-command register and go to EXEC.
- State EXEC (exactly one cycle):
  - alu_x = acc[15:0], alu_y = cur.data, alu_op = cur.op.
  - Outside EXEC, alu_* hold their last values.
  - At the end of the cycle:
    - If cur.load: acc <= {0, cur.data}, res_data <= same, res_err <= 0.
    - Else if alu_err: acc <= 0, res_data <= 0, res_err <= 1.
    - Else: acc <= alu_out, res_data <= alu_out, res_err <= 0.
  - Next state is RESP.
- State RESP:
  - res_valid = 1. res_data and res_err are held stable until the handshake.
  - On res_ready:
    - If res_err: go to ERROR and flush the queue (count and pointers reset).
    - Else: ops_done++ (wraps to 0 at max). If the queue is non-empty, pop and go to EXEC directly; otherwise go to IDLE.
- State ERROR:
  - cmd_ready 0, err_state 1, res_valid 0, accumulator 0.
  - err_clear goes to IDLE next cycle. err_clear in any other state is ignored.
- Timing and throughput:
  - Latency from command accept to res_valid is 3 cycles when idle with an empty queue.
  - Back-to-back throughput is 1 result per 2 cycles with res_ready tied high.
- Shift and NOT ops ignore alu_y; the sequencer still drives cur.data.
- The accumulator is 17 bits. Only bits 15:0 feed alu_x; bit 16 is retained and visible only in res_data.

Decomposition:
- Shared package (alu_seq_pkg) holds:
  - op-code constants OP_ADD..OP_NOT
  - state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2, ERROR=2'd3
  - command record layout (load, op, data = 20 bits)
- One sub-module: cmd_fifo, a synchronous FIFO with parameters FIFO_DEPTH and width 20, exposing push, pop, flush, full, empty, head.
- The FSM, accumulator and counter stay in the top module.

Test Plan:
- Load 0x0005, then add 0x0003, res_ready=1 → results 0x00005, then 0x00008. res_err 0 on both. ops_done=2. First res_valid 3 cycles after the first accept.
- Load 0x0008, sub 0x0003, shl, shr → results 0x00005, 0x0000A, 0x00005. Check alu_op=001, 010, 011 during the EXEC cycles.
- Load 0xFFFF, add 0x0001 → res_err 1, res_data 0. After the handshake: err_state 1 and cmd_ready 0. Queued commands are flushed and never executed. Pulse err_clear → IDLE with acc 0. ops_done unchanged.
- res_ready=0, push 6 commands back-to-back → 5 accepted, 6th sees cmd_ready=0. Raise res_ready → 5 results in order, 2 cycles apart.
- Load 0x00F0, and 0x0FF0, or 0x000F, xor 0x00FF, not → 0x000F0, 0x000F0, 0x000FF, 0x00000, 0x0FFFF.
- Assert reset during EXEC of a queued burst → next cycle: all outputs at reset values, queue empty, accumulator 0, no res_valid.
